// File: rtl/fpadd_pkg.sv
// Shared widths, state encoding and result format for the FP adder add/normalize stage.
package fpadd_pkg;

  localparam int unsigned MANT_W = 24;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = MANT_W - 1;
  localparam int unsigned SUM_W  = MANT_W + 1;
  localparam int unsigned WEXP_W = EXP_W + 1;

  localparam logic [EXP_W-1:0] EXP_INF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } an_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fpadd_pack.sv
// Combinational binary32 packer: zero, infinity, denormal and normal encodings.
//   sign_i : result sign
//   e_i    : working exponent (9-bit, biased)
//   sum_i  : working mantissa (25-bit, bit 23 is the hidden bit)
//   res_o  : packed binary32 result
module fpadd_pack
  import fpadd_pkg::*;
(
  input  logic              sign_i,
  input  logic [WEXP_W-1:0] e_i,
  input  logic [SUM_W-1:0]  sum_i,
  output fp32_t             res_o
);

  always_comb begin
    res_o = '0;
    if (sum_i == '0) begin
      // Exact cancellation always yields +0.
      res_o = '0;
    end else if (e_i >= WEXP_W'(EXP_INF)) begin
      res_o.sign = sign_i;
      res_o.exp  = EXP_INF;
      res_o.frac = '0;
    end else if (sum_i[FRAC_W]) begin
      res_o.sign = sign_i;
      res_o.exp  = e_i[EXP_W-1:0];
      res_o.frac = sum_i[FRAC_W-1:0];
    end else begin
      // Hidden bit clear at minimum exponent: denormal encoding.
      res_o.sign = sign_i;
      res_o.exp  = '0;
      res_o.frac = sum_i[FRAC_W-1:0];
    end
  end

endmodule

// File: rtl/fpadd_addnorm.sv
// Mantissa add/subtract and iterative (1 bit/cycle) normalization stage.
//   clk, reset    : clock, async active-high reset
//   in_valid/in_ready   : input handshake
//   shifted_mant  : aligned smaller-exponent mantissa (24b)
//   big_mant      : larger-exponent mantissa (24b)
//   big_exp       : larger-exponent biased exponent (8b)
//   sign_big      : sign of larger operand
//   eff_sub       : perform subtraction
//   out_valid/out_ready : output handshake
//   result        : packed binary32 sum
module fpadd_addnorm
  import fpadd_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] shifted_mant,
  input  logic [23:0] big_mant,
  input  logic [7:0]  big_exp,
  input  logic        sign_big,
  input  logic        eff_sub,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result
);

  an_state_t          state_q, state_d;
  logic [MANT_W-1:0]  shifted_q, shifted_d;
  logic [MANT_W-1:0]  big_mant_q, big_mant_d;
  logic [EXP_W-1:0]   big_exp_q, big_exp_d;
  logic               sign_big_q, sign_big_d;
  logic               eff_sub_q, eff_sub_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [WEXP_W-1:0]  e_q, e_d;
  logic               sign_q, sign_d;
  fp32_t              result_q, result_d;
  logic               out_valid_q;
  logic               in_ready_q;

  logic [SUM_W-1:0]   sum_pk_c;
  logic [WEXP_W-1:0]  e_pk_c;
  fp32_t              packed_c;

  // A carry-out is folded into the packer input so one instance serves all exits.
  assign sum_pk_c = sum_q[SUM_W-1] ? (sum_q >> 1) : sum_q;
  assign e_pk_c   = sum_q[SUM_W-1] ? (e_q + WEXP_W'(1)) : e_q;

  fpadd_pack u_pack (
    .sign_i (sign_q),
    .e_i    (e_pk_c),
    .sum_i  (sum_pk_c),
    .res_o  (packed_c)
  );

  // Next-state and datapath.
  always_comb begin
    state_d    = state_q;
    shifted_d  = shifted_q;
    big_mant_d = big_mant_q;
    big_exp_d  = big_exp_q;
    sign_big_d = sign_big_q;
    eff_sub_d  = eff_sub_q;
    sum_d      = sum_q;
    e_d        = e_q;
    sign_d     = sign_q;
    result_d   = result_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shifted_d  = shifted_mant;
          big_mant_d = big_mant;
          big_exp_d  = big_exp;
          sign_big_d = sign_big;
          eff_sub_d  = eff_sub;
          state_d    = ADD;
        end
      end
      ADD: begin
        if (!eff_sub_q) begin
          sum_d  = {1'b0, big_mant_q} + {1'b0, shifted_q};
          sign_d = sign_big_q;
        end else if (shifted_q > big_mant_q) begin
          sum_d  = {1'b0, shifted_q} - {1'b0, big_mant_q};
          sign_d = ~sign_big_q;
        end else begin
          sum_d  = {1'b0, big_mant_q} - {1'b0, shifted_q};
          sign_d = sign_big_q;
        end
        // Denormal inputs share the minimum exponent of 1.
        e_d = (big_exp_q == '0) ? WEXP_W'(1) : {1'b0, big_exp_q};
        if (big_exp_q == EXP_INF) begin
          result_d = {sign_big_q, EXP_INF, big_mant_q[FRAC_W-1:0]};
          state_d  = DONE;
        end else begin
          state_d = NORM;
        end
      end
      NORM: begin
        if (sum_q == '0) begin
          result_d = packed_c;
          state_d  = DONE;
        end else if (sum_q[SUM_W-1]) begin
          sum_d = sum_pk_c;
          e_d   = e_pk_c;
          if (e_pk_c == WEXP_W'(EXP_INF)) begin
            result_d = packed_c;
            state_d  = DONE;
          end
        end else if (sum_q[FRAC_W] || (e_q == WEXP_W'(1))) begin
          result_d = packed_c;
          state_d  = DONE;
        end else begin
          sum_d = sum_q << 1;
          e_d   = e_q - WEXP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shifted_q   <= '0;
      big_mant_q  <= '0;
      big_exp_q   <= '0;
      sign_big_q  <= 1'b0;
      eff_sub_q   <= 1'b0;
      sum_q       <= '0;
      e_q         <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      shifted_q   <= shifted_d;
      big_mant_q  <= big_mant_d;
      big_exp_q   <= big_exp_d;
      sign_big_q  <= sign_big_d;
      eff_sub_q   <= eff_sub_d;
      sum_q       <= sum_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      result_q    <= result_d;
      out_valid_q <= (state_d == DONE);
      in_ready_q  <= (state_d == IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;

endmodule
